// File: rtl/data_mem_lsu_if.sv
// Core-side load/store bus for data_mem_lsu: request operands toward the LSU,
// load result and stall/completion status back to the core.
interface data_mem_lsu_if;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] ReadData;
   logic        Stall;
   logic        Done;
   logic        Misaligned;

   modport master (
      output Addr, WriteData, MemRead, MemWrite, Funct3,
      input  ReadData, Stall, Done, Misaligned
   );

   modport slave (
      input  Addr, WriteData, MemRead, MemWrite, Funct3,
      output ReadData, Stall, Done, Misaligned
   );
endinterface

// File: rtl/data_mem_lsu.sv
// Load/store unit with internal word-organised data memory and a programmable-latency
// stall FSM. Optional feature: define LSU_ALIGN_CHECK_EN to fault misaligned H/W accesses.
module data_mem_lsu #(
   parameter int MEM_WORDS = 256,
   parameter int LATENCY   = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   data_mem_lsu_if.slave bus
);

   localparam int         IDX_W    = $clog2(MEM_WORDS);
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t             state;
   state_t             next_state;
   logic [3:0]         cnt;
   logic [IDX_W+1:0]   addr_q;
   logic [31:0]        wdata_q;
   logic [2:0]         f3_q;
   logic               wr_q;
   logic [31:0]        rdata;
   logic               fault_q;

   logic               req;
   logic               accept;
   logic               enter_done;
   logic               use_in;

   logic [IDX_W-1:0]   acc_idx;
   logic [1:0]         acc_off;
   logic [31:0]        acc_wdata;
   logic [2:0]         acc_f3;
   logic               acc_wr;
   logic               f3_fault;
   logic               align_fault;
   logic               acc_fault;

   logic [31:0]        mem [MEM_WORDS];
   logic               mem_we;
   logic [3:0]         st_be;
   logic [31:0]        st_data;
   logic [31:0]        rd_word;
   logic [7:0]         rd_byte;
   logic [15:0]        rd_half;
   logic [31:0]        load_val;

   // Address bits above the word index alias onto the same array entries.
   logic               unused_addr;
   assign unused_addr = ^bus.Addr[31:IDX_W+2];

   assign req = bus.MemRead | bus.MemWrite;

   // In IDLE the access may complete on this very edge, so operands come straight
   // from the bus; afterwards the latched copies are used.
   assign use_in    = (state == S_IDLE);
   assign acc_idx   = use_in ? bus.Addr[2 +: IDX_W] : addr_q[2 +: IDX_W];
   assign acc_off   = use_in ? bus.Addr[1:0]        : addr_q[1:0];
   assign acc_wdata = use_in ? bus.WriteData        : wdata_q;
   assign acc_f3    = use_in ? bus.Funct3           : f3_q;
   assign acc_wr    = use_in ? bus.MemWrite         : wr_q;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      f3_fault = 1'b1;
      case (acc_f3)
         3'b000, 3'b001, 3'b010: f3_fault = 1'b0;
         3'b100, 3'b101:         f3_fault = acc_wr;
         default:                f3_fault = 1'b1;
      endcase
   end

`ifdef LSU_ALIGN_CHECK_EN
   assign align_fault = ((acc_f3[1:0] == 2'b01) && acc_off[0]) ||
                        ((acc_f3[1:0] == 2'b10) && (acc_off != 2'b00));
`else
   assign align_fault = 1'b0;
`endif

   assign acc_fault = f3_fault | align_fault;

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      enter_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) begin
               accept = 1'b1;
               if ((LATENCY == 0) || acc_fault) begin
                  next_state = S_DONE;
                  enter_done = 1'b1;
               end else begin
                  next_state = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               next_state = S_DONE;
               enter_done = 1'b1;
            end
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Store lane enables and replicated data; misaligned H/W force-align by lane choice.
   always_comb begin
      st_be   = 4'b0000;
      st_data = acc_wdata;
      case (acc_f3[1:0])
         2'b00: begin
            st_be   = 4'b0001 << acc_off;
            st_data = {4{acc_wdata[7:0]}};
         end
         2'b01: begin
            st_be   = acc_off[1] ? 4'b1100 : 4'b0011;
            st_data = {2{acc_wdata[15:0]}};
         end
         2'b10:   st_be = 4'b1111;
         default: st_be = 4'b0000;
      endcase
   end

   always_comb begin
      rd_word  = mem[acc_idx];
      rd_byte  = rd_word[{acc_off, 3'b000} +: 8];
      rd_half  = acc_off[1] ? rd_word[31:16] : rd_word[15:0];
      load_val = rd_word;
      case (acc_f3[1:0])
         2'b00:   load_val = acc_f3[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
         2'b01:   load_val = acc_f3[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
         default: load_val = rd_word;
      endcase
   end

   assign mem_we = enter_done & acc_wr & ~acc_fault;

   // NOTE: the data array has no reset; its contents survive rst_n like a real SRAM.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (st_be[i]) mem[acc_idx][8*i +: 8] <= st_data[8*i +: 8];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         f3_q    <= 3'b000;
         wr_q    <= 1'b0;
         rdata   <= 32'h0;
         fault_q <= 1'b0;
      end else begin
         state <= next_state;
         if (accept) begin
            addr_q  <= bus.Addr[IDX_W+1:0];
            wdata_q <= bus.WriteData;
            f3_q    <= bus.Funct3;
            wr_q    <= bus.MemWrite;
            cnt     <= CNT_INIT;
         end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_done) begin
            fault_q <= acc_fault;
            if (!acc_wr && !acc_fault) rdata <= load_val;
         end
      end
   end

   assign bus.ReadData   = rdata;
   assign bus.Done       = (state == S_DONE);
   assign bus.Misaligned = (state == S_DONE) & fault_q;
   assign bus.Stall      = rst_n & (((state == S_IDLE) & req) | (state == S_WAIT));

endmodule
